ask4_tx_mapper: RTL and testbench

//  Transmit-side 4-ASK symbol mapper: the counterpart of the receive slicer/reference chain.

---
 rtl/ask4_tx_mapper.sv | 133 +++++++++++++
 tb/tb_ask4_tx_mapper.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ask4_tx_mapper.sv
// 4-ASK transmit mapper: symbol FIFO, Gray map to +/-a / +/-3a (1s17), zero-stuff to OSR.
// Optional macro TX_LFSR_SRC_EN adds src_sel and an internal LFSR test-symbol source.
module ask4_tx_mapper #(
  parameter int OSR        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LFSR_LEN   = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               samp_en,
  input  logic [1:0]         sym_data,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [16:0]        amp,
  output logic signed [17:0] tx_out,
  output logic               sym_strobe,
  output logic               underflow
`ifdef TX_LFSR_SRC_EN
  ,
  input  logic               src_sel
`endif
);

  localparam int PW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit PARAMS_OK = (OSR >= 2) && (FIFO_DEPTH >= 2) && (LFSR_LEN >= 2);

  generate
    if (!PARAMS_OK) begin : g_bad_params
    end
  endgenerate

  function automatic logic [16:0] sat_triple(input logic [16:0] a);
    logic [18:0] t;
    t = {2'b00, a} + {1'b0, a, 1'b0};
    return (|t[18:17]) ? 17'h1FFFF : t[16:0];
  endfunction

  // Gray map: bit 1 selects sign, bit 0 selects inner (a) versus outer (3a) level
  function automatic logic signed [17:0] map_sym(input logic [1:0] s, input logic [16:0] a);
    logic [16:0]        mag;
    logic signed [17:0] pos;
    mag = s[0] ? a : sat_triple(a);
    pos = signed'({1'b0, mag});
    return s[1] ? pos : -pos;
  endfunction

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [PW-1:0] phase;
  logic          full, empty, push, pop, phase0, src_lfsr;
  logic [1:0]    head;

  logic signed [17:0] tx_p0;
  logic               vld_p0;
  logic               uf_p0;

`ifdef TX_LFSR_SRC_EN
  logic [LFSR_LEN-1:0] lfsr, lfsr_s1, lfsr_s2;
  assign src_lfsr = src_sel;
  assign lfsr_s1  = {lfsr[LFSR_LEN-2:0], lfsr[LFSR_LEN-1] ^ lfsr[LFSR_LEN-2]};
  assign lfsr_s2  = {lfsr_s1[LFSR_LEN-2:0], lfsr_s1[LFSR_LEN-1] ^ lfsr_s1[LFSR_LEN-2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= '1;
    else if (samp_en && (phase == '0) && src_sel)
      lfsr <= lfsr_s2;
  end
`else
  assign src_lfsr = 1'b0;
`endif

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign sym_ready = !full && !src_lfsr;
  assign push      = sym_valid && sym_ready;
  assign phase0    = samp_en && (phase == '0);
  assign pop       = phase0 && !src_lfsr && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];

  // Push side: runs on every clk, independent of samp_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 2'b00;
    end else if (push) begin
      wr_ptr                <= wr_ptr + 1'b1;
      mem[wr_ptr[AW-1:0]]   <= sym_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_ptr <= '0;
    else if (pop)
      rd_ptr <= rd_ptr + 1'b1;
  end

  // Stage p0: sample-rate output register, advances only on samp_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      tx_p0  <= '0;
      vld_p0 <= 1'b0;
      uf_p0  <= 1'b0;
    end else if (samp_en) begin
      phase <= (phase == PW'(OSR - 1)) ? '0 : phase + 1'b1;
      if (phase == '0) begin
        vld_p0 <= 1'b1;
`ifdef TX_LFSR_SRC_EN
        if (src_lfsr)
          tx_p0 <= map_sym(lfsr_s2[1:0], amp);
        else
`endif
        if (!empty) begin
          tx_p0 <= map_sym(head, amp);
        end else begin
          tx_p0 <= '0;
          uf_p0 <= 1'b1;
        end
      end else begin
        tx_p0  <= '0;
        vld_p0 <= 1'b0;
      end
    end
  end

  assign tx_out     = tx_p0;
  assign sym_strobe = vld_p0;
  assign underflow  = uf_p0;

endmodule

// File: tb/tb_ask4_tx_mapper.sv
// Self-checking bench for ask4_tx_mapper: queue-based reference model, directed and random stimulus.
module tb_ask4_tx_mapper;
  localparam int OSR   = 4;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               samp_en;
  logic [1:0]         sym_data;
  logic               sym_valid;
  logic               sym_ready;
  logic [16:0]        amp;
  logic signed [17:0] tx_out;
  logic               sym_strobe;
  logic               underflow;

  int checks = 0;
  int errors = 0;

  int q[$];
  int ph;
  int m_tx;
  int m_stb;
  int m_uf;

  always #5 clk = ~clk;

  ask4_tx_mapper #(.OSR(OSR), .FIFO_DEPTH(DEPTH), .LFSR_LEN(22)) dut (
    .clk       (clk),
    .reset     (reset),
    .samp_en   (samp_en),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .amp       (amp),
    .tx_out    (tx_out),
    .sym_strobe(sym_strobe),
    .underflow (underflow)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int level(input int s, input int a);
    int m;
    m = s[0] ? a : ((3 * a > 131071) ? 131071 : 3 * a);
    return s[1] ? m : -m;
  endfunction

  task automatic model_reset();
    q.delete();
    ph    = 0;
    m_tx  = 0;
    m_stb = 0;
    m_uf  = 0;
  endtask

  // One clock: predict from pre-edge inputs/state, then compare #1 after the edge
  task automatic step();
    int  d, a;
    bit  do_push;
    d       = sym_data;
    a       = amp;
    do_push = sym_valid && (q.size() < DEPTH);
    @(posedge clk);
    if (samp_en) begin
      if (ph == 0) begin
        m_stb = 1;
        if (q.size() > 0) m_tx = level(q.pop_front(), a);
        else begin
          m_tx = 0;
          m_uf = 1;
        end
      end else begin
        m_tx  = 0;
        m_stb = 0;
      end
      ph = (ph + 1) % OSR;
    end
    if (do_push) q.push_back(d);
    #1;
    check("tx_out", int'(tx_out), m_tx);
    check("sym_strobe", int'(sym_strobe), m_stb);
    check("underflow", int'(underflow), m_uf);
    check("sym_ready", int'(sym_ready), (q.size() < DEPTH) ? 1 : 0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_tx_out", int'(tx_out), 0);
    check("rst_sym_strobe", int'(sym_strobe), 0);
    check("rst_underflow", int'(underflow), 0);
    check("rst_sym_ready", int'(sym_ready), 1);
    @(negedge clk);
    reset     = 1'b0;
    sym_valid = 1'b0;
    samp_en   = 1'b0;
  endtask

  task automatic push_idle(input logic [1:0] s);
    samp_en   = 1'b0;
    sym_valid = 1'b1;
    sym_data  = s;
    step();
    sym_valid = 1'b0;
  endtask

  initial begin
    int exp1 [16] = '{30000, 0, 0, 0, 10000, 0, 0, 0, -10000, 0, 0, 0, -30000, 0, 0, 0};
    logic [1:0] syms4 [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    int idx;

    reset     = 1'b1;
    samp_en   = 1'b0;
    sym_valid = 1'b0;
    sym_data  = 2'b00;
    amp       = 17'd10000;
    do_reset();

    // Test 1: basic level sequence
    push_idle(2'b10); push_idle(2'b11); push_idle(2'b01); push_idle(2'b00);
    samp_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("t1_seq", int'(tx_out), exp1[i]);
    end

    // Test 2: saturation of 3a
    do_reset();
    amp = 17'h1FFFF;
    push_idle(2'b10); push_idle(2'b00);
    samp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) check("t2_pos_sat", int'(tx_out), 131071);
      if (i == 4) check("t2_neg_sat", int'(tx_out), -131071);
    end

    // Test 3: underflow with no pushes
    do_reset();
    amp     = 17'd10000;
    samp_en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("t3_underflow_sticky", int'(underflow), 1);

    // Test 4: fill while idle, then drain in order
    do_reset();
    amp       = 17'd777;
    idx       = 0;
    sym_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sym_data = syms4[idx];
      if (sym_ready && idx < 5) begin
        step();
        idx++;
      end else step();
    end
    check("t4_accepted", idx, 4);
    samp_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (idx < 5) begin
        sym_valid = 1'b1;
        sym_data  = syms4[idx];
        if (sym_ready) begin
          step();
          idx++;
        end else step();
      end else begin
        sym_valid = 1'b0;
        step();
      end
    end
    check("t4_all_pushed", idx, 5);

    // Test 5: sparse samp_en keeps the level stable between enables
    do_reset();
    amp = 17'd5000;
    push_idle(2'b01);
    for (int i = 0; i < 15; i++) begin
      samp_en = (i % 3 == 0);
      step();
    end

    // Test 6: reset mid-symbol discards queued symbols
    do_reset();
    amp = 17'd1234;
    push_idle(2'b10); push_idle(2'b00); push_idle(2'b01); push_idle(2'b10);
    samp_en = 1'b1;
    step(); step();
    check("t6_queued", q.size(), 3);
    do_reset();
    push_idle(2'b11);
    samp_en = 1'b1;
    step();
    check("t6_new_sym", int'(tx_out), 1234);
    for (int i = 0; i < 7; i++) step();

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      samp_en   = ($urandom_range(0, 9) < 6);
      sym_valid = ($urandom_range(0, 9) < 4);
      sym_data  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) amp = 17'($urandom);
      step();
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
